// File: rtl/ms_tmr32_evt_cond.sv
// ms_tmr32_evt_cond -- conditions the asynchronous external counter input
// for ms_tmr32: synchronizer -> programmable glitch filter -> edge detector.
// Produces a filtered level and single-cycle pos/neg/selected-edge pulses
// in the clk_i domain.
//
// Optional feature macro: MS_TMR32_EVT_GLITCH_CNT_EN
//   defined   : glitch_clr / glitch_cnt ports and a 16-bit saturating
//               count of rejected pulses are built.
//   undefined : those ports and the counter are absent; filtering is unchanged.
//
// Filter FSM (IDLE / STABLE / QUAL):
//   IDLE   : ctr_lvl tracks the synchronized input, no pulses; moves to
//            STABLE when enabled, so enabling never creates an edge.
//   STABLE : waits for the synchronized input to differ from ctr_lvl.
//   QUAL   : counts consecutive mismatching cycles; accepts the new level
//            once cnt >= flt_len, otherwise a return to the old level is a
//            rejected glitch.
//   en=0 forces IDLE from any state.
module ms_tmr32_evt_cond #(
   parameter int SYNC_STAGES = 2,
   parameter int FLT_W       = 8
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             en,
   input  logic             ctr_in,
   input  logic [FLT_W-1:0] flt_len,
   input  logic [1:0]       edge_sel,
   output logic             ctr_lvl,
   output logic             ctr_pos,
   output logic             ctr_neg,
   output logic             ctr_evt
`ifdef MS_TMR32_EVT_GLITCH_CNT_EN
   ,
   input  logic             glitch_clr,
   output logic [15:0]      glitch_cnt
`endif
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_STABLE = 2'd1,
      ST_QUAL   = 2'd2
   } state_t;

   localparam logic [FLT_W-1:0] CNT_MAX = {FLT_W{1'b1}};
   localparam logic [FLT_W-1:0] CNT_ONE = FLT_W'(1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   s;
   state_t                 state;
   logic [FLT_W-1:0]       cnt;

   assign s = sync_q[SYNC_STAGES-1];

   // Synchronizer chain; runs regardless of en so s is always current.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], ctr_in};
      end
   end

   // Glitch-filter FSM with registered level and edge pulses.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state   <= ST_IDLE;
         cnt     <= '0;
         ctr_lvl <= 1'b0;
         ctr_pos <= 1'b0;
         ctr_neg <= 1'b0;
         ctr_evt <= 1'b0;
      end else begin
         ctr_pos <= 1'b0;
         ctr_neg <= 1'b0;
         ctr_evt <= 1'b0;
         if (!en) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            ctr_lvl <= s;
         end else begin
            case (state)
               ST_IDLE: begin
                  ctr_lvl <= s;
                  cnt     <= '0;
                  state   <= ST_STABLE;
               end
               ST_STABLE: begin
                  if (s != ctr_lvl) begin
                     cnt   <= CNT_ONE;
                     state <= ST_QUAL;
                  end else begin
                     cnt <= '0;
                  end
               end
               ST_QUAL: begin
                  if (s == ctr_lvl) begin
                     cnt   <= '0;
                     state <= ST_STABLE;
                  end else if (cnt >= flt_len) begin
                     ctr_lvl <= s;
                     cnt     <= '0;
                     state   <= ST_STABLE;
                     ctr_pos <= s;
                     ctr_neg <= ~s;
                     ctr_evt <= s ? edge_sel[0] : edge_sel[1];
                  end else if (cnt != CNT_MAX) begin
                     cnt <= cnt + CNT_ONE;
                  end
               end
               default: begin
                  state <= ST_IDLE;
                  cnt   <= '0;
               end
            endcase
         end
      end
   end

`ifdef MS_TMR32_EVT_GLITCH_CNT_EN
   logic glitch_hit;

   // A glitch is a return to the old level while a change is being qualified.
   assign glitch_hit = en && (state == ST_QUAL) && (s == ctr_lvl);

   // Saturating count of rejected pulses; a clear beats a same-cycle glitch.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         glitch_cnt <= 16'h0000;
      end else if (glitch_clr) begin
         glitch_cnt <= 16'h0000;
      end else if (glitch_hit && (glitch_cnt != 16'hFFFF)) begin
         glitch_cnt <= glitch_cnt + 16'h0001;
      end
   end
`endif

endmodule
